// File: rtl/pcg16_pkg.sv
`default_nettype none
// ============================================================================
// Module : pcg16_pkg
// Brief  : Constants, FSM state type and output-shift helper for the PCG16 stream checker.
// Rev    : 1.0
// ============================================================================
package pcg16_pkg;

    localparam logic [15:0] PCG_MULT     = 16'd12829;
    localparam logic [15:0] PCG_INC      = 16'd47989;
    localparam logic [15:0] PCG_OUT_MULT = 16'd62169;
    localparam logic [15:0] PCG_SEED     = 16'd4356;

    typedef enum logic [1:0] {
        SEEK    = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } chk_state_e;

    // Output permutation shift: top three state bits select a shift of 3..10.
    function automatic logic [3:0] pcg_out_shift(input logic [15:0] s);
        return {1'b0, s[15:13]} + 4'd3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcg16_stream_checker_if.sv
`default_nettype none
// ============================================================================
// Module : pcg16_stream_checker_if
// Brief  : Byte-stream input and status outputs of the PCG16 stream checker.
// Rev    : 1.0
// ============================================================================
interface pcg16_stream_checker_if #(
    parameter int CNT_W = 16
) ();

    logic             in_valid;
    logic [7:0]       in_data;
    logic             locked;
    logic             lost;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] match_cnt;
    logic [7:0]       exp_data;

    modport master (
        output in_valid, in_data,
        input  locked, lost, err_cnt, match_cnt, exp_data
    );

    modport slave (
        input  in_valid, in_data,
        output locked, lost, err_cnt, match_cnt, exp_data
    );

endinterface
`default_nettype wire

// File: rtl/pcg16_step.sv
`default_nettype none
// ============================================================================
// Module : pcg16_step
// Brief  : Combinational PCG16 step: next state and output byte for a state.
// Rev    : 1.0
// ============================================================================
module pcg16_step
    import pcg16_pkg::*;
(
    input  wire logic [15:0] s,
    output logic      [15:0] next_s,
    output logic      [7:0]  out_byte
);

    logic [15:0] w_x;
    logic [15:0] w_prod;

    always_comb begin
        w_x      = (s >> pcg_out_shift(s)) ^ s;
        w_prod   = w_x * PCG_OUT_MULT;
        out_byte = w_prod[15:8];
        next_s   = s * PCG_MULT + PCG_INC;
    end

endmodule
`default_nettype wire

// File: rtl/pcg16_stream_checker.sv
`default_nettype none
// ============================================================================
// Module : pcg16_stream_checker
// Brief  : Regenerates the PCG16 byte stream from SEED, locks onto the received
//          stream and counts matches/mismatches while locked.
//          PCG_CHK_RESYNC_EN: LOST returns to SEEK after one cycle (else sticky).
// Rev    : 1.0
// ============================================================================
module pcg16_stream_checker
    import pcg16_pkg::*;
#(
    parameter logic [15:0] SEED       = PCG_SEED,
    parameter int          LOCK_COUNT = 4,
    parameter int          LOSS_LIMIT = 3,
    parameter int          CNT_W      = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    pcg16_stream_checker_if.slave bus
);

    localparam int RUN_W  = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
    localparam int MISS_W = (LOSS_LIMIT > 1) ? $clog2(LOSS_LIMIT + 1) : 1;

    chk_state_e       fsm_q,       fsm_d;
    logic [15:0]      gen_q,       gen_d;
    logic [RUN_W-1:0] run_q,       run_d;
    logic [MISS_W-1:0] miss_q,     miss_d;
    logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

    logic [15:0] w_trk_next;
    logic [7:0]  w_trk_byte;
    logic [15:0] w_seed_next;
    logic [7:0]  w_seed_byte;
    logic        w_trk_hit;
    logic        w_seed_hit;

    pcg16_step u_trk_step (
        .s        (gen_q),
        .next_s   (w_trk_next),
        .out_byte (w_trk_byte)
    );

    // Constant-input instance for re-testing a LOCKING mismatch against the stream start.
    pcg16_step u_seed_step (
        .s        (SEED),
        .next_s   (w_seed_next),
        .out_byte (w_seed_byte)
    );

    assign w_trk_hit  = (bus.in_data == w_trk_byte);
    assign w_seed_hit = (bus.in_data == w_seed_byte);

    always_comb begin
        fsm_d       = fsm_q;
        gen_d       = gen_q;
        run_d       = run_q;
        miss_d      = miss_q;
        err_cnt_d   = err_cnt_q;
        match_cnt_d = match_cnt_q;

        case (fsm_q)
            SEEK: begin
                if (bus.in_valid && w_seed_hit) begin
                    gen_d = w_seed_next;
                    run_d = RUN_W'(1);
                    if (LOCK_COUNT == 1) begin
                        fsm_d  = LOCKED;
                        miss_d = '0;
                    end else begin
                        fsm_d = LOCKING;
                    end
                end
            end

            LOCKING: begin
                if (bus.in_valid) begin
                    if (w_trk_hit) begin
                        gen_d = w_trk_next;
                        run_d = run_q + RUN_W'(1);
                        if (run_q + RUN_W'(1) == RUN_W'(LOCK_COUNT)) begin
                            fsm_d  = LOCKED;
                            miss_d = '0;
                        end
                    end else if (w_seed_hit) begin
                        gen_d = w_seed_next;
                        run_d = RUN_W'(1);
                    end else begin
                        gen_d = SEED;
                        run_d = '0;
                        fsm_d = SEEK;
                    end
                end
            end

            LOCKED: begin
                if (bus.in_valid) begin
                    gen_d = w_trk_next;
                    if (w_trk_hit) begin
                        miss_d = '0;
                        if (match_cnt_q != '1) begin
                            match_cnt_d = match_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        miss_d = miss_q + MISS_W'(1);
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                        if (miss_q + MISS_W'(1) == MISS_W'(LOSS_LIMIT)) begin
                            fsm_d = LOST;
                        end
                    end
                end
            end

            LOST: begin
`ifdef PCG_CHK_RESYNC_EN
                fsm_d  = SEEK;
                gen_d  = SEED;
                run_d  = '0;
                miss_d = '0;
`else
                fsm_d  = LOST;
`endif
            end

            default: begin
                fsm_d = SEEK;
                gen_d = SEED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q       <= SEEK;
            gen_q       <= SEED;
            run_q       <= '0;
            miss_q      <= '0;
            err_cnt_q   <= '0;
            match_cnt_q <= '0;
        end else begin
            fsm_q       <= fsm_d;
            gen_q       <= gen_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            err_cnt_q   <= err_cnt_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign bus.locked    = (fsm_q == LOCKED);
    assign bus.lost      = (fsm_q == LOST);
    assign bus.err_cnt   = err_cnt_q;
    assign bus.match_cnt = match_cnt_q;
    assign bus.exp_data  = w_trk_byte;

endmodule
`default_nettype wire

// File: tb/tb_pcg16_stream_checker.sv
`default_nettype none
// ============================================================================
// Module : tb_pcg16_stream_checker
// Brief  : Directed-vector bench for pcg16_stream_checker (honours PCG_CHK_RESYNC_EN).
// Rev    : 1.0
// ============================================================================
module tb_pcg16_stream_checker;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pcg16_stream_checker_if #(.CNT_W(16)) bus ();

    pcg16_stream_checker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stream from SEED 16'd4356, computed by hand.
    logic [7:0] seq [9] = '{8'h41, 8'hA0, 8'h3C, 8'h9B, 8'h45, 8'hFB, 8'h0A, 8'hAE, 8'hCA};

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       lk;
        logic       ls;
        int         err;
        int         mt;
        logic       ce;
        logic [7:0] ed;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic lk, input logic ls, input int err,
                           input int mt, input logic ce, input logic [7:0] ed);
        chk({tag, " locked"},    32'(bus.locked),    32'(lk));
        chk({tag, " lost"},      32'(bus.lost),      32'(ls));
        chk({tag, " err_cnt"},   32'(bus.err_cnt),   32'(err));
        chk({tag, " match_cnt"}, 32'(bus.match_cnt), 32'(mt));
        if (ce) chk({tag, " exp_data"}, 32'(bus.exp_data), 32'(ed));
    endtask

    task automatic put(input logic v, input logic [7:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic lock_up();
        for (int i = 0; i < 4; i++) put(1'b1, seq[i]);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Lock-up, a single corrupted byte and idle gaps in one stream.
        tbl[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 0, 0, 1'b1, 8'hA0};
        tbl[1]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 0, 0, 1'b1, 8'h3C};
        tbl[2]  = '{1'b0, 8'h55, 1'b0, 1'b0, 0, 0, 1'b1, 8'h3C};
        tbl[3]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 0, 0, 1'b1, 8'h9B};
        tbl[4]  = '{1'b1, 8'h9B, 1'b1, 1'b0, 0, 0, 1'b1, 8'h45};
        tbl[5]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1, 0, 1'b1, 8'hFB};
        tbl[6]  = '{1'b1, 8'hFB, 1'b1, 1'b0, 1, 1, 1'b1, 8'h0A};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1, 1'b1, 8'h0A};
        tbl[8]  = '{1'b1, 8'h0A, 1'b1, 1'b0, 1, 2, 1'b1, 8'hAE};
        tbl[9]  = '{1'b1, 8'hAE, 1'b1, 1'b0, 1, 3, 1'b1, 8'hCA};
        tbl[10] = '{1'b1, 8'hCA, 1'b1, 1'b0, 1, 4, 1'b0, 8'h00};

        do_reset();
        chk_all("reset", 1'b0, 1'b0, 0, 0, 1'b1, 8'h41);
        for (int i = 0; i < 11; i++) begin
            put(tbl[i].v, tbl[i].d);
            chk_all($sformatf("vec%0d", i), tbl[i].lk, tbl[i].ls, tbl[i].err, tbl[i].mt,
                    tbl[i].ce, tbl[i].ed);
        end

        // Garbage never leaves SEEK.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            put(1'b1, 8'h00);
            chk_all($sformatf("seek%0d", i), 1'b0, 1'b0, 0, 0, 1'b1, 8'h41);
        end

        // Three consecutive corrupted bytes while locked.
        do_reset();
        lock_up();
        chk_all("loss_lock", 1'b1, 1'b0, 0, 0, 1'b1, 8'h45);
        put(1'b1, 8'h45 ^ 8'hFF);
        chk_all("loss_m1", 1'b1, 1'b0, 1, 0, 1'b1, 8'hFB);
        put(1'b1, 8'hFB ^ 8'hFF);
        chk_all("loss_m2", 1'b1, 1'b0, 2, 0, 1'b1, 8'h0A);
        put(1'b1, 8'h0A ^ 8'hFF);
        chk_all("loss_m3", 1'b0, 1'b1, 3, 0, 1'b0, 8'h00);
`ifdef PCG_CHK_RESYNC_EN
        put(1'b1, 8'h41);
        chk_all("resync_seek", 1'b0, 1'b0, 3, 0, 1'b1, 8'h41);
        lock_up();
        chk_all("resync_lock", 1'b1, 1'b0, 3, 0, 1'b1, 8'h45);
`else
        for (int i = 0; i < 10; i++) begin
            put(1'b1, seq[i % 4]);
            chk_all($sformatf("sticky%0d", i), 1'b0, 1'b1, 3, 0, 1'b0, 8'h00);
        end
`endif

        // LOCKING mismatch that restarts the stream, then one that falls back to SEEK.
        do_reset();
        put(1'b1, 8'h41);
        chk_all("restart_a", 1'b0, 1'b0, 0, 0, 1'b1, 8'hA0);
        put(1'b1, 8'h41);
        chk_all("restart_b", 1'b0, 1'b0, 0, 0, 1'b1, 8'hA0);
        put(1'b1, 8'hA0);
        chk_all("restart_c", 1'b0, 1'b0, 0, 0, 1'b1, 8'h3C);
        put(1'b1, 8'h3C);
        chk_all("restart_d", 1'b0, 1'b0, 0, 0, 1'b1, 8'h9B);
        put(1'b1, 8'h9B);
        chk_all("restart_e", 1'b1, 1'b0, 0, 0, 1'b1, 8'h45);
        do_reset();
        put(1'b1, 8'h41);
        put(1'b1, 8'h00);
        chk_all("fallback", 1'b0, 1'b0, 0, 0, 1'b1, 8'h41);
        put(1'b1, 8'hA0);
        chk_all("fallback_stay", 1'b0, 1'b0, 0, 0, 1'b1, 8'h41);

        // Valid gaps while locked, then a one-cycle reset with a valid byte present.
        do_reset();
        lock_up();
        for (int b = 4; b < 7; b++) begin
            put(1'b1, seq[b]);
            for (int g = 0; g < 3; g++) put(1'b0, 8'h5A);
            chk_all($sformatf("gap%0d", b), 1'b1, 1'b0, 0, b - 3, 1'b1, seq[b+1]);
        end
        rst_n = 1'b0;
        put(1'b1, 8'hAE);
        rst_n = 1'b1;
        chk_all("rst_mid", 1'b0, 1'b0, 0, 0, 1'b1, 8'h41);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
